bin2bcd_seq_ctrl: RTL



---
 rtl/bin2bcd_pkg.sv | 46 ++++
 rtl/bcd_add3.sv | 20 ++
 rtl/bin2bcd_seq_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types, constants and constant functions for the sequential
// binary-to-BCD converter (bin2bcd_seq_ctrl and bcd_add3).
package bin2bcd_pkg;

    // Controller phases: waiting for input, iterating, holding a result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // A digit at or above this value would overflow past 9 after doubling.
    localparam logic [3:0] ADD3_THRESH = 4'd5;
    localparam logic [3:0] ADD3_VAL    = 4'd3;

    // Ceiling log2; clog2(1) = 0, clog2(9) = 4.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 32'd0;
        for (int unsigned i = 32'd0; i < 32'd32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 32'd1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // True when dig_n decimal digits can hold every bin_w-bit value,
    // i.e. 10^dig_n > 2^bin_w.
    function automatic bit digits_cover(input int unsigned bin_w, input int unsigned dig_n);
        longint unsigned p10;
        longint unsigned p2;
        p10 = 64'd1;
        p2  = 64'd1;
        for (int unsigned i = 32'd0; (i < dig_n) && (i < 32'd19); i++) begin
            p10 = p10 * 64'd10;
        end
        for (int unsigned i = 32'd0; (i < bin_w) && (i < 32'd63); i++) begin
            p2 = p2 * 64'd2;
        end
        return (p10 > p2);
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Combinational double-dabble digit corrector: a BCD digit of 5 or more
// gets +3 so that the following left shift carries correctly into the
// next decimal digit. The 4-bit add never needs a carry out (max 12).
module bcd_add3
    import bin2bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // Conditional add-3 on a single digit.
    always_comb begin
        if (digit_i >= ADD3_THRESH) begin
            digit_o = digit_i + ADD3_VAL;
        end else begin
            digit_o = digit_i;
        end
    end

endmodule

// File: rtl/bin2bcd_seq_ctrl.sv
// Sequential binary-to-BCD controller (double dabble, one bit per cycle).
// A value accepted on the input handshake is shifted through a shared
// bank of per-digit add-3 correctors for BIN_W cycles; the finished BCD
// word is then presented with out_valid until the consumer takes it.
// Optional build macro: BIN2BCD_SEQ_DIGCNT_EN adds the ndig output
// (count of significant decimal digits, minimum 1).
module bin2bcd_seq_ctrl
    import bin2bcd_pkg::*;
#(
    parameter int unsigned BIN_W = 8,
    parameter int unsigned DIG_N = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   EN,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BIN_W-1:0]       bin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*DIG_N-1:0]     bcd,
    output logic                   busy
`ifdef BIN2BCD_SEQ_DIGCNT_EN
    ,
    output logic [clog2(DIG_N + 32'd1)-1:0] ndig
`endif
);

    localparam int unsigned CNT_W = clog2(BIN_W + 32'd1);
    localparam int unsigned BCD_W = 32'd4 * DIG_N;
    localparam int unsigned TOT_W = BCD_W + BIN_W;

    // Too few digits for the input range is a configuration error.
    if (!digits_cover(BIN_W, DIG_N)) begin : g_dig_n_too_small
        $error("bin2bcd_seq_ctrl: DIG_N too small, need 10^DIG_N > 2^BIN_W");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_sh_q, bin_sh_d;
    logic [BCD_W-1:0]   work_q, work_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic [BCD_W-1:0]   corr_s;
    logic [TOT_W-1:0]   shifted_s;
    logic [BCD_W-1:0]   work_next_s;
    logic [BIN_W-1:0]   bin_next_s;
    logic               last_iter_s;

`ifdef BIN2BCD_SEQ_DIGCNT_EN
    localparam int unsigned NDIG_W = clog2(DIG_N + 32'd1);

    logic [NDIG_W-1:0]  ndig_q, ndig_d;

    // Index of the most significant non-zero digit plus one; zero reads as one digit.
    function automatic logic [NDIG_W-1:0] sig_digits(input logic [BCD_W-1:0] v);
        logic [NDIG_W-1:0] n;
        n = NDIG_W'(32'd1);
        for (int unsigned i = 32'd0; i < DIG_N; i++) begin
            if (v[4*i +: 4] != 4'd0) begin
                n = NDIG_W'(i + 32'd1);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction
`endif

    // One corrector per digit, all operating on the working BCD register.
    for (genvar g = 0; g < DIG_N; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (work_q[4*g +: 4]),
            .digit_o (corr_s[4*g +: 4])
        );
    end

    // One double-dabble iteration: corrected digits and binary shifted left together.
    always_comb begin
        shifted_s   = {corr_s, bin_sh_q} << 1'b1;
        work_next_s = shifted_s[TOT_W-1 -: BCD_W];
        bin_next_s  = shifted_s[BIN_W-1:0];
        last_iter_s = (cnt_q == CNT_W'(32'd1));
    end

    // Input side may accept only when idle, or when the held result leaves this cycle.
    assign in_ready = EN & ((state_q == IDLE) | ((state_q == DONE) & out_ready));

    // Next-state and datapath control; everything holds while EN is low.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bin_sh_d    = bin_sh_q;
        work_d      = work_q;
        bcd_d       = bcd_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
`ifdef BIN2BCD_SEQ_DIGCNT_EN
        ndig_d      = ndig_q;
`endif
        if (EN) begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_d  = SHIFT;
                        cnt_d    = CNT_W'(BIN_W);
                        bin_sh_d = bin;
                        work_d   = {BCD_W{1'b0}};
                        busy_d   = 1'b1;
                    end else begin
                        state_d  = IDLE;
                    end
                end
                SHIFT: begin
                    bin_sh_d = bin_next_s;
                    work_d   = work_next_s;
                    cnt_d    = cnt_q - CNT_W'(32'd1);
                    if (last_iter_s) begin
                        state_d     = DONE;
                        bcd_d       = work_next_s;
                        out_valid_d = 1'b1;
                        busy_d      = 1'b0;
`ifdef BIN2BCD_SEQ_DIGCNT_EN
                        ndig_d      = sig_digits(work_next_s);
`endif
                    end else begin
                        state_d     = SHIFT;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        if (in_valid) begin
                            // Back-to-back: the next value starts without an idle cycle.
                            state_d  = SHIFT;
                            cnt_d    = CNT_W'(BIN_W);
                            bin_sh_d = bin;
                            work_d   = {BCD_W{1'b0}};
                            busy_d   = 1'b1;
                        end else begin
                            state_d  = IDLE;
                        end
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            bin_sh_q    <= {BIN_W{1'b0}};
            work_q      <= {BCD_W{1'b0}};
            bcd_q       <= {BCD_W{1'b0}};
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef BIN2BCD_SEQ_DIGCNT_EN
            ndig_q      <= {NDIG_W{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bin_sh_q    <= bin_sh_d;
            work_q      <= work_d;
            bcd_q       <= bcd_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef BIN2BCD_SEQ_DIGCNT_EN
            ndig_q      <= ndig_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign bcd       = bcd_q;
`ifdef BIN2BCD_SEQ_DIGCNT_EN
    assign ndig      = ndig_q;
`endif

endmodule
